// File: rtl/lpif_online_sequencer.sv
// rtl/lpif_online_sequencer.sv - LPIF link bring-up sequencer driving tx_online/rx_online
// Optional automatic retry on rx timeout: define LPIF_ONLINE_SEQ_RETRY_EN.
module lpif_online_sequencer #(
    parameter int NUM_CH    = 8,
    parameter int STB_MATCH = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic              clk_wr,
    input  logic              rst_wr_n,
    input  logic              seq_enable,
    input  logic [NUM_CH-1:0] phy_ready,
    input  logic              phy_align_done,
    input  logic              rx_stb_detect,
    input  logic [15:0]       settle_cycles,
    input  logic [15:0]       rx_timeout_cycles,
    input  logic              err_clear,
    output logic              tx_online,
    output logic              rx_online,
    output logic              link_up,
    output logic              link_error,
    output logic [31:0]       debug_status
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_PHY = 3'd1,
        S_SETTLE   = 3'd2,
        S_TX_ON    = 3'd3,
        S_RX_ON    = 3'd4,
        S_ERROR    = 3'd5
    } state_t;

    localparam logic [3:0] STB_MATCH_C = 4'(STB_MATCH);
    localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  stb_cnt_q, stb_cnt_d;
    logic [3:0]  retry_cnt_q, retry_cnt_d;
    logic        tx_online_q, tx_online_d;
    logic        rx_online_q, rx_online_d;
    logic        link_up_q, link_up_d;
    logic        link_error_q, link_error_d;
    logic        phy_ok;
    logic        tmo_en;

    assign phy_ok = (&phy_ready) & phy_align_done;
    assign tmo_en = (rx_timeout_cycles != 16'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stb_cnt_d   = stb_cnt_q;
        retry_cnt_d = retry_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (seq_enable) state_d = S_WAIT_PHY;
            end
            S_WAIT_PHY: begin
                if (phy_ok) begin
                    state_d = S_SETTLE;
                    cnt_d   = settle_cycles;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 16'd0) begin
                    state_d   = S_TX_ON;
                    cnt_d     = rx_timeout_cycles;
                    stb_cnt_d = 4'd0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_TX_ON: begin
                if (rx_stb_detect && (stb_cnt_q < STB_MATCH_C)) stb_cnt_d = stb_cnt_q + 4'd1;
                if (tmo_en && (cnt_q != 16'd0)) cnt_d = cnt_q - 16'd1;
                // A strobe match in the expiry cycle still brings the link up
                if (stb_cnt_d == STB_MATCH_C) begin
                    state_d     = S_RX_ON;
                    retry_cnt_d = 4'd0;
                end else if (tmo_en && (cnt_d == 16'd0)) begin
                    state_d = S_ERROR;
                end
            end
            S_RX_ON: begin
                state_d = S_RX_ON;
            end
            S_ERROR: begin
`ifdef LPIF_ONLINE_SEQ_RETRY_EN
                if (err_clear) begin
                    state_d = S_IDLE;
                end else if (retry_cnt_q < MAX_RETRY_C) begin
                    state_d     = S_WAIT_PHY;
                    retry_cnt_d = retry_cnt_q + 4'd1;
                end
`else
                if (err_clear) state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (!phy_ok && (state_q == S_SETTLE || state_q == S_TX_ON || state_q == S_RX_ON))
            state_d = S_WAIT_PHY;
        if (!seq_enable)
            state_d = S_IDLE;

        if (state_d == S_IDLE) begin
            cnt_d       = 16'd0;
            stb_cnt_d   = 4'd0;
            retry_cnt_d = 4'd0;
        end

        tx_online_d  = (state_d == S_TX_ON) || (state_d == S_RX_ON);
        rx_online_d  = (state_d == S_RX_ON);
        link_up_d    = (state_d == S_RX_ON);
        link_error_d = (state_d == S_ERROR);
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 16'd0;
            stb_cnt_q    <= 4'd0;
            retry_cnt_q  <= 4'd0;
            tx_online_q  <= 1'b0;
            rx_online_q  <= 1'b0;
            link_up_q    <= 1'b0;
            link_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stb_cnt_q    <= stb_cnt_d;
            retry_cnt_q  <= retry_cnt_d;
            tx_online_q  <= tx_online_d;
            rx_online_q  <= rx_online_d;
            link_up_q    <= link_up_d;
            link_error_q <= link_error_d;
        end
    end

    assign tx_online    = tx_online_q;
    assign rx_online    = rx_online_q;
    assign link_up      = link_up_q;
    assign link_error   = link_error_q;
    assign debug_status = {16'h0, retry_cnt_q, stb_cnt_q, 5'h0, state_q};

endmodule

// File: tb/tb_lpif_online_sequencer.sv
// tb/tb_lpif_online_sequencer.sv - directed self-checking bench for lpif_online_sequencer
module tb_lpif_online_sequencer;

    logic        clk_wr = 1'b0;
    logic        rst_wr_n;
    logic        seq_enable;
    logic [7:0]  phy_ready;
    logic        phy_align_done;
    logic        rx_stb_detect;
    logic [15:0] settle_cycles;
    logic [15:0] rx_timeout_cycles;
    logic        err_clear;
    logic        tx_online, rx_online, link_up, link_error;
    logic [31:0] debug_status;

    int total = 0;
    int bad   = 0;

    lpif_online_sequencer #(.NUM_CH(8), .STB_MATCH(2), .MAX_RETRY(3)) dut (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .seq_enable(seq_enable),
        .phy_ready(phy_ready), .phy_align_done(phy_align_done),
        .rx_stb_detect(rx_stb_detect), .settle_cycles(settle_cycles),
        .rx_timeout_cycles(rx_timeout_cycles), .err_clear(err_clear),
        .tx_online(tx_online), .rx_online(rx_online), .link_up(link_up),
        .link_error(link_error), .debug_status(debug_status)
    );

    always #5 clk_wr = ~clk_wr;

    task automatic tick();
        @(posedge clk_wr);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int rises;
        logic prev_err;

        rst_wr_n = 1'b0; seq_enable = 1'b0; phy_ready = 8'hFF; phy_align_done = 1'b1;
        rx_stb_detect = 1'b0; settle_cycles = 16'd10; rx_timeout_cycles = 16'd0; err_clear = 1'b0;
        #12;
        check("rst_tx", {31'h0, tx_online}, 32'h0);
        check("rst_rx", {31'h0, rx_online}, 32'h0);
        check("rst_err", {31'h0, link_error}, 32'h0);
        check("rst_dbg", debug_status, 32'h0);
        tick();
        rst_wr_n = 1'b1;
        tick();
        check("idle_hold", debug_status, 32'h0);

        // Nominal bring-up
        seq_enable = 1'b1;
        tick();
        check("nom_wait_phy", debug_status, 32'h1);
        n = 0;
        while (!tx_online && n < 50) begin
            tick();
            n++;
        end
        check("nom_tx_latency", n, 12);
        check("nom_tx_state", debug_status, 32'h3);
        check("nom_rx_low", {31'h0, rx_online}, 32'h0);
        rx_stb_detect = 1'b1; tick(); rx_stb_detect = 1'b0;
        check("nom_stb1", debug_status, 32'h0000_0103);
        tick(); tick();
        check("nom_rx_still_low", {31'h0, rx_online}, 32'h0);
        rx_stb_detect = 1'b1; tick(); rx_stb_detect = 1'b0;
        check("nom_rx_on", debug_status, 32'h0000_0204);
        check("nom_link_up", {29'h0, tx_online, rx_online, link_up}, 32'h7);

        // PHY loss in RX_ON, then re-sequence with settle_cycles=0
        phy_ready = 8'hFE;
        tick();
        check("loss_state", debug_status[2:0], 32'h1);
        check("loss_outs", {29'h0, tx_online, rx_online, link_up}, 32'h0);
        phy_ready = 8'hFF; settle_cycles = 16'd0;
        tick();
        check("reseq_settle", debug_status[2:0], 32'h2);
        tick();
        check("reseq_one_settle", debug_status, 32'h3);
        check("reseq_tx", {31'h0, tx_online}, 32'h1);
        rx_stb_detect = 1'b1; tick(); tick(); rx_stb_detect = 1'b0;
        check("reseq_rx_on", {29'h0, tx_online, rx_online, link_up}, 32'h7);

        // seq_enable low from RX_ON and from SETTLE
        seq_enable = 1'b0;
        tick();
        check("dis_rx_idle", debug_status, 32'h0);
        check("dis_rx_outs", {29'h0, tx_online, rx_online, link_up}, 32'h0);
        settle_cycles = 16'd10; seq_enable = 1'b1;
        tick(); tick(); tick();
        check("dis_in_settle", debug_status[2:0], 32'h2);
        seq_enable = 1'b0;
        tick();
        check("dis_settle_idle", debug_status, 32'h0);

        // Timeout without strobes
        settle_cycles = 16'd0; rx_timeout_cycles = 16'd20; seq_enable = 1'b1;
        tick(); tick(); tick();
        check("tmo_tx_cycle1", debug_status, 32'h3);
        repeat (19) tick();
        check("tmo_cycle20", {28'h0, debug_status[2:0], link_error}, {28'h0, 3'd3, 1'b0});
        tick();
        check("tmo_cycle21_state", debug_status[2:0], 32'h5);
        check("tmo_cycle21_outs", {29'h0, tx_online, rx_online, link_error}, 32'h1);
`ifdef LPIF_ONLINE_SEQ_RETRY_EN
        tick();
        check("tmo_retry_wait", debug_status, 32'h0000_1001);
        check("tmo_retry_err_pulse", {31'h0, link_error}, 32'h0);
`else
        phy_ready = 8'h7F;
        tick();
        check("tmo_phy_loss_ignored", debug_status, 32'h5);
        phy_ready = 8'hFF;
        tick();
        check("tmo_sticky", {31'h0, link_error}, 32'h1);
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        check("tmo_err_clear", debug_status[2:0], 32'h0);
        check("tmo_err_low", {31'h0, link_error}, 32'h0);
`endif
        seq_enable = 1'b0;
        tick();
        check("tmo_back_idle", debug_status, 32'h0);

        // Second strobe lands in the cycle the timeout expires
        seq_enable = 1'b1;
        tick(); tick(); tick();
        rx_stb_detect = 1'b1; tick(); rx_stb_detect = 1'b0;
        repeat (18) tick();
        check("sim_cycle20", debug_status, 32'h0000_0103);
        rx_stb_detect = 1'b1; tick(); rx_stb_detect = 1'b0;
        check("sim_rx_on", debug_status, 32'h0000_0204);
        check("sim_no_err", {31'h0, link_error}, 32'h0);
        check("sim_rx", {31'h0, rx_online}, 32'h1);

        // Asynchronous reset mid-cycle
        #3 rst_wr_n = 1'b0;
        #1;
        check("arst_outs", {28'h0, tx_online, rx_online, link_up, link_error}, 32'h0);
        check("arst_dbg", debug_status, 32'h0);
        tick();
        rst_wr_n = 1'b1;
        seq_enable = 1'b0;
        tick();

        // Retry behaviour with no strobes
        rx_timeout_cycles = 16'd5; seq_enable = 1'b1;
        rises = 0; prev_err = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (link_error && !prev_err) rises++;
            prev_err = link_error;
        end
`ifdef LPIF_ONLINE_SEQ_RETRY_EN
        check("retry_rises", rises, 4);
        check("retry_sticky", {31'h0, link_error}, 32'h1);
        check("retry_dbg", debug_status, 32'h0000_3005);
`else
        check("noretry_rises", rises, 1);
        check("noretry_dbg", debug_status, 32'h0000_0005);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
